// File: rtl/agnus_pkg.sv
// Shared types and constants for the Agnus chip-RAM DMA slot scheduler.
package agnus_pkg;

  typedef enum logic [3:0] {
    OWN_IDLE     = 4'd0,
    OWN_REFRESH  = 4'd1,
    OWN_DISK     = 4'd2,
    OWN_AUDIO    = 4'd3,
    OWN_SPRITE   = 4'd4,
    OWN_BITPLANE = 4'd5,
    OWN_COPPER   = 4'd6,
    OWN_BLITTER  = 4'd7,
    OWN_CPU      = 4'd8
  } owner_t;

  localparam int DMAEN = 9;
  localparam int BPLEN = 8;
  localparam int COPEN = 7;
  localparam int BLTEN = 6;
  localparam int SPREN = 5;
  localparam int DSKEN = 4;

  localparam logic [7:0] SLOT_REFRESH_LAST = 8'h07;
  localparam logic [7:0] SLOT_DISK0        = 8'h09;
  localparam logic [7:0] SLOT_DISK_LAST    = 8'h0D;
  localparam logic [7:0] SLOT_AUD0         = 8'h0F;
  localparam logic [7:0] SLOT_AUD_LAST     = 8'h15;
  localparam logic [7:0] SLOT_SPR0         = 8'h17;
  localparam logic [7:0] SLOT_SPR_LAST     = 8'h35;

  // Fetch-slot offset within an 8-cycle group -> plane number (0 = no plane)
  function automatic logic [2:0] plane_of(input logic [2:0] off);
    case (off)
      3'd7:    plane_of = 3'd1;
      3'd3:    plane_of = 3'd2;
      3'd5:    plane_of = 3'd3;
      3'd1:    plane_of = 3'd4;
      3'd6:    plane_of = 3'd5;
      3'd2:    plane_of = 3'd6;
      default: plane_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/agnus_beam_counter.sv
// Horizontal/vertical beam counters with registered start-of-line/frame pulses.
module agnus_beam_counter #(
  parameter int HPOS_MAX = 226,
  parameter int LINES    = 312
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] hpos,
  output logic [8:0] vpos,
  output logic       sol,
  output logic       sof
);

  localparam logic [7:0] HMAX = 8'(HPOS_MAX);
  localparam logic [8:0] VMAX = 9'(LINES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
      sol  <= 1'b0;
      sof  <= 1'b0;
    end else begin
      sol <= (hpos == HMAX);
      sof <= (hpos == HMAX) && (vpos == VMAX);
      if (hpos == HMAX) begin
        hpos <= '0;
        vpos <= (vpos == VMAX) ? 9'd0 : vpos + 9'd1;
      end else begin
        hpos <= hpos + 8'd1;
      end
    end
  end

endmodule

// File: rtl/agnus_dma_slot_arbiter.sv
// Per-colour-clock chip-bus slot arbiter; owner is registered (latency 1).
// Optional AGNUS_BLIT_NICE_EN adds the CPU starvation counter for blitter-nice mode.
module agnus_dma_slot_arbiter
  import agnus_pkg::*;
#(
  parameter int HPOS_MAX = 226,
  parameter int LINES    = 312
) (
  input  logic       CCK,
  input  logic       RES,
  input  logic [9:0] dmacon,
  input  logic       blt_pri,
  input  logic [7:0] ddfstrt,
  input  logic [7:0] ddfstop,
  input  logic [2:0] nplanes,
  input  logic       bpl_vwin,
  input  logic       dsk_req,
  input  logic [3:0] aud_req,
  input  logic [7:0] spr_req,
  input  logic       cop_req,
  input  logic       blt_req,
  input  logic       cpu_req,
  output logic [7:0] hpos,
  output logic [8:0] vpos,
  output owner_t     owner,
  output logic [2:0] owner_idx,
  output logic       dma_cycle,
  output logic       cpu_grant,
  output logic       sol,
  output logic       sof
);

  agnus_beam_counter #(.HPOS_MAX(HPOS_MAX), .LINES(LINES)) u_beam (
    .clk (CCK),
    .rst (RES),
    .hpos(hpos),
    .vpos(vpos),
    .sol (sol),
    .sof (sof)
  );

  logic       dmaen, odd;
  logic       refresh_slot, disk_slot, aud_slot, spr_slot;
  logic [1:0] aud_n;
  logic [2:0] spr_n, plane, np_eff;
  logic       bpl_win, bpl_hit, cpu_force;
  owner_t     nxt_owner;
  logic [2:0] nxt_idx;

  assign dmaen        = dmacon[DMAEN];
  assign odd          = hpos[0];
  assign refresh_slot = odd && (hpos <= SLOT_REFRESH_LAST);
  assign disk_slot    = odd && (hpos >= SLOT_DISK0) && (hpos <= SLOT_DISK_LAST);
  assign aud_slot     = odd && (hpos >= SLOT_AUD0) && (hpos <= SLOT_AUD_LAST);
  assign spr_slot     = odd && (hpos >= SLOT_SPR0) && (hpos <= SLOT_SPR_LAST);
  assign aud_n        = 2'((hpos - SLOT_AUD0) >> 1);
  assign spr_n        = 3'((hpos - SLOT_SPR0) >> 2);

  // Window compared in 9 bits so a stop of 0xF8+ still closes past 0xFF
  assign bpl_win = dmaen && dmacon[BPLEN] && bpl_vwin && (ddfstrt <= ddfstop) &&
                   ({1'b0, hpos} >= {1'b0, ddfstrt & 8'hF8}) &&
                   ({1'b0, hpos} <  ({1'b0, ddfstop & 8'hF8} + 9'd8));
  assign np_eff  = (nplanes == 3'd7) ? 3'd6 : nplanes;
  assign plane   = plane_of(hpos[2:0]);
  assign bpl_hit = bpl_win && (plane != 3'd0) && (plane <= np_eff);

`ifdef AGNUS_BLIT_NICE_EN
  logic [1:0] cpu_miss;

  assign cpu_force = !blt_pri && (cpu_miss == 2'd3) && cpu_req;

  always_ff @(posedge CCK or posedge RES) begin
    if (RES)
      cpu_miss <= 2'd0;
    else if (blt_pri || !cpu_req || nxt_owner == OWN_CPU)
      cpu_miss <= 2'd0;
    else if (nxt_owner == OWN_BLITTER)
      cpu_miss <= cpu_miss + 2'd1;
  end
`else
  logic unused_blt_pri;
  assign unused_blt_pri = blt_pri;
  assign cpu_force      = 1'b0;
`endif

  always_comb begin
    nxt_owner = OWN_IDLE;
    nxt_idx   = 3'd0;
    if (refresh_slot) begin
      nxt_owner = OWN_REFRESH;
    end else if (disk_slot && dmaen && dmacon[DSKEN] && dsk_req) begin
      nxt_owner = OWN_DISK;
    end else if (aud_slot && dmaen && dmacon[aud_n] && aud_req[aud_n]) begin
      nxt_owner = OWN_AUDIO;
      nxt_idx   = {1'b0, aud_n};
    end else if (bpl_hit) begin
      nxt_owner = OWN_BITPLANE;
      nxt_idx   = plane - 3'd1;
    end else if (spr_slot && dmaen && dmacon[SPREN] && spr_req[spr_n]) begin
      nxt_owner = OWN_SPRITE;
      nxt_idx   = spr_n;
    end else if (cpu_force) begin
      nxt_owner = OWN_CPU;
    end else if (!odd && dmaen && dmacon[COPEN] && cop_req) begin
      nxt_owner = OWN_COPPER;
    end else if (dmaen && dmacon[BLTEN] && blt_req) begin
      nxt_owner = OWN_BLITTER;
    end else if (cpu_req) begin
      nxt_owner = OWN_CPU;
    end
  end

  always_ff @(posedge CCK or posedge RES) begin
    if (RES) begin
      owner     <= OWN_IDLE;
      owner_idx <= 3'd0;
      dma_cycle <= 1'b0;
      cpu_grant <= 1'b0;
    end else begin
      owner     <= nxt_owner;
      owner_idx <= nxt_idx;
      dma_cycle <= (nxt_owner != OWN_IDLE) && (nxt_owner != OWN_CPU);
      cpu_grant <= (nxt_owner == OWN_CPU);
    end
  end

endmodule

// File: tb/tb_agnus_dma_slot_arbiter.sv
// Directed, table-driven bench for agnus_dma_slot_arbiter plus multi-cycle sequences.
module tb_agnus_dma_slot_arbiter;
  import agnus_pkg::*;

  logic       CCK = 1'b0;
  logic       RES = 1'b1;
  logic [9:0] dmacon = '0;
  logic       blt_pri = 1'b1;
  logic [7:0] ddfstrt = '0, ddfstop = '0;
  logic [2:0] nplanes = '0;
  logic       bpl_vwin = 1'b0, dsk_req = 1'b0, cop_req = 1'b0, blt_req = 1'b0, cpu_req = 1'b0;
  logic [3:0] aud_req = '0;
  logic [7:0] spr_req = '0;
  logic [7:0] hpos;
  logic [8:0] vpos;
  owner_t     owner;
  logic [2:0] owner_idx;
  logic       dma_cycle, cpu_grant, sol, sof;

  agnus_dma_slot_arbiter dut (
    .CCK(CCK), .RES(RES), .dmacon(dmacon), .blt_pri(blt_pri),
    .ddfstrt(ddfstrt), .ddfstop(ddfstop), .nplanes(nplanes), .bpl_vwin(bpl_vwin),
    .dsk_req(dsk_req), .aud_req(aud_req), .spr_req(spr_req), .cop_req(cop_req),
    .blt_req(blt_req), .cpu_req(cpu_req), .hpos(hpos), .vpos(vpos),
    .owner(owner), .owner_idx(owner_idx), .dma_cycle(dma_cycle),
    .cpu_grant(cpu_grant), .sol(sol), .sof(sof)
  );

  always #5 CCK = ~CCK;

  typedef struct {
    logic [7:0] hp;
    logic [9:0] dmacon;
    logic [7:0] strt, stop;
    logic [2:0] np;
    logic       vwin, dsk;
    logic [3:0] aud;
    logic [7:0] spr;
    logic       cop, blt, cpu;
    owner_t     eo;
    logic [2:0] ei;
  } vec_t;

  vec_t vt[$];
  int   pass_cnt = 0;
  int   total = 0;

  function automatic vec_t mk(logic [7:0] hp, logic [9:0] dc, logic [7:0] strt, logic [7:0] stop,
                              logic [2:0] np, logic vwin, logic dsk, logic [3:0] aud,
                              logic [7:0] spr, logic cop, logic blt, logic cpu,
                              owner_t eo, logic [2:0] ei);
    vec_t v;
    v.hp = hp; v.dmacon = dc; v.strt = strt; v.stop = stop; v.np = np; v.vwin = vwin;
    v.dsk = dsk; v.aud = aud; v.spr = spr; v.cop = cop; v.blt = blt; v.cpu = cpu;
    v.eo = eo; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_hpos(input logic [7:0] h);
    int n = 0;
    while (hpos !== h && n < 400) begin
      @(negedge CCK);
      n++;
    end
    if (n >= 400) chk("wait_hpos timeout", 0, 1);
  endtask

  task automatic chk_owner(input string name, input owner_t eo, input logic [2:0] ei);
    chk({name, " owner"}, int'(owner), int'(eo));
    chk({name, " idx"}, int'(owner_idx), int'(ei));
    chk({name, " dma_cycle"}, int'(dma_cycle), int'(eo != OWN_IDLE && eo != OWN_CPU));
    chk({name, " cpu_grant"}, int'(cpu_grant), int'(eo == OWN_CPU));
  endtask

  initial begin
    int n;
    owner_t exp_o;

    // hp, dmacon, strt, stop, np, vwin, dsk, aud, spr, cop, blt, cpu, owner, idx
    vt.push_back(mk(8'h01, 10'h000, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 0, 0, 1, OWN_REFRESH, 0));
    vt.push_back(mk(8'h02, 10'h000, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h07, 10'h000, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 0, 0, 1, OWN_REFRESH, 0));
    vt.push_back(mk(8'h40, 10'h1FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'hFF, 1, 1, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h09, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'h00, 0, 0, 0, OWN_DISK, 0));
    vt.push_back(mk(8'h0D, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'h00, 0, 0, 0, OWN_DISK, 0));
    vt.push_back(mk(8'h0F, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'h00, 0, 0, 0, OWN_AUDIO, 0));
    vt.push_back(mk(8'h11, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'h00, 0, 0, 0, OWN_AUDIO, 1));
    vt.push_back(mk(8'h13, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'h00, 0, 0, 0, OWN_AUDIO, 2));
    vt.push_back(mk(8'h15, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 1, 4'hF, 8'h00, 0, 0, 0, OWN_AUDIO, 3));
    vt.push_back(mk(8'h11, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h37, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h38, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h39, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 3));
    vt.push_back(mk(8'h3A, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h3B, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 1));
    vt.push_back(mk(8'h3D, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 2));
    vt.push_back(mk(8'h3E, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h3F, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 0));
    vt.push_back(mk(8'hD7, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 0));
    vt.push_back(mk(8'hD9, 10'h3FF, 8'h38, 8'hD0, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h3A, 10'h3FF, 8'h38, 8'hD0, 3'd7, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 5));
    vt.push_back(mk(8'h3C, 10'h3FF, 8'h38, 8'hD0, 3'd7, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h3E, 10'h3FF, 8'h38, 8'hD0, 3'd7, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_BITPLANE, 4));
    vt.push_back(mk(8'h39, 10'h3FF, 8'hD0, 8'h38, 3'd4, 1, 0, 4'h0, 8'h00, 0, 0, 1, OWN_CPU, 0));
    vt.push_back(mk(8'h17, 10'h3FF, 8'h18, 8'hD0, 3'd1, 1, 0, 4'h0, 8'hFF, 0, 0, 0, OWN_SPRITE, 0));
    vt.push_back(mk(8'h1B, 10'h3FF, 8'h18, 8'hD0, 3'd1, 1, 0, 4'h0, 8'hFF, 0, 0, 0, OWN_SPRITE, 1));
    vt.push_back(mk(8'h1D, 10'h3FF, 8'h18, 8'hD0, 3'd1, 1, 0, 4'h0, 8'hFF, 0, 0, 0, OWN_SPRITE, 1));
    vt.push_back(mk(8'h1F, 10'h3FF, 8'h18, 8'hD0, 3'd1, 1, 0, 4'h0, 8'hFF, 0, 0, 0, OWN_BITPLANE, 0));
    vt.push_back(mk(8'h35, 10'h3FF, 8'h18, 8'hD0, 3'd1, 1, 0, 4'h0, 8'hFF, 0, 0, 0, OWN_SPRITE, 7));
    vt.push_back(mk(8'h40, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 1, 1, 1, OWN_COPPER, 0));
    vt.push_back(mk(8'h41, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 1, 1, 1, OWN_BLITTER, 0));
    vt.push_back(mk(8'h40, 10'h37F, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 1, 1, 1, OWN_BLITTER, 0));
    vt.push_back(mk(8'h50, 10'h3FF, 8'h00, 8'h00, 3'd0, 0, 0, 4'h0, 8'h00, 0, 0, 0, OWN_IDLE, 0));

    // Reset state
    cpu_req = 1'b1;
    repeat (3) @(negedge CCK);
    chk("reset hpos", int'(hpos), 0);
    chk("reset vpos", int'(vpos), 0);
    chk_owner("reset", OWN_IDLE, 0);
    chk("reset sol", int'(sol), 0);
    chk("reset sof", int'(sof), 0);
    RES = 1'b0;

    // Line period: sol every 227 clocks, vpos steps on the wrap
    n = 0;
    while (!sol && n < 300) begin @(negedge CCK); n++; end
    chk("first sol seen", int'(sol), 1);
    chk("vpos after first line", int'(vpos), 1);
    chk("sof on line 1", int'(sof), 0);
    chk("hpos at sol", int'(hpos), 0);
    @(negedge CCK);
    n = 1;
    while (!sol && n < 300) begin @(negedge CCK); n++; end
    chk("sol period", n, 227);

    foreach (vt[i]) begin
      dmacon = vt[i].dmacon; ddfstrt = vt[i].strt; ddfstop = vt[i].stop;
      nplanes = vt[i].np; bpl_vwin = vt[i].vwin; dsk_req = vt[i].dsk;
      aud_req = vt[i].aud; spr_req = vt[i].spr; cop_req = vt[i].cop;
      blt_req = vt[i].blt; cpu_req = vt[i].cpu; blt_pri = 1'b1;
      wait_hpos(vt[i].hp);
      @(posedge CCK);
      @(negedge CCK);
      chk_owner($sformatf("vec%0d hp=%02h", i, vt[i].hp), vt[i].eo, vt[i].ei);
    end

    // Blitter vs CPU in a run of free slots, starting from a cleared counter
    dmacon = 10'h3FF; bpl_vwin = 1'b0; cop_req = 1'b0; dsk_req = 1'b0;
    aud_req = '0; spr_req = '0; blt_req = 1'b1; blt_pri = 1'b0; cpu_req = 1'b0;
    wait_hpos(8'h40);
    cpu_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge CCK);
      @(negedge CCK);
`ifdef AGNUS_BLIT_NICE_EN
      exp_o = (i % 4 == 3) ? OWN_CPU : OWN_BLITTER;
`else
      exp_o = OWN_BLITTER;
`endif
      chk_owner($sformatf("nice slot %0d", i), exp_o, 0);
    end
    blt_pri = 1'b1;
    wait_hpos(8'h40);
    for (int i = 0; i < 8; i++) begin
      @(posedge CCK);
      @(negedge CCK);
      chk_owner($sformatf("nasty slot %0d", i), OWN_BLITTER, 0);
    end

    // Reset mid-line at vpos 100, hpos 0x60
    n = 0;
    while (!(vpos == 9'd100 && hpos == 8'h60) && n < 40000) begin @(negedge CCK); n++; end
    chk("reach vpos100 hpos60", int'(vpos == 9'd100 && hpos == 8'h60), 1);
    RES = 1'b1;
    #1;
    chk("midreset hpos", int'(hpos), 0);
    chk("midreset vpos", int'(vpos), 0);
    chk_owner("midreset", OWN_IDLE, 0);
    @(negedge CCK);
    RES = 1'b0;
    @(posedge CCK);
    @(negedge CCK);
    chk("post-reset hpos", int'(hpos), 1);
    chk("post-reset vpos", int'(vpos), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
